// File: rtl/bldc_pkg.sv
// Shared types and constants for the six-step BLDC commutator.
// Pure declarations plus the commutation table helper; no timing of its own.
// No flow control; the commutator cannot stall its PWM source.
package bldc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DEAD,
      ST_DRIVE,
      ST_FAULT
   } state_t;

   typedef enum logic [1:0] {
      PH_A,
      PH_B,
      PH_C
   } phase_t;

   // Hall codes {Ha,Hb,Hc}; 000 and 111 never occur on a healthy motor.
   localparam logic [2:0] CODE_NONE = 3'b000;
   localparam logic [2:0] CODE_001  = 3'b001;
   localparam logic [2:0] CODE_010  = 3'b010;
   localparam logic [2:0] CODE_011  = 3'b011;
   localparam logic [2:0] CODE_100  = 3'b100;
   localparam logic [2:0] CODE_101  = 3'b101;
   localparam logic [2:0] CODE_110  = 3'b110;
   localparam logic [2:0] CODE_ALL  = 3'b111;

   // Bit positions inside GATE = {AH,AL,BH,BL,CH,CL}.
   localparam int AH = 5;
   localparam int AL = 4;
   localparam int BH = 3;
   localparam int BL = 2;
   localparam int CH = 1;
   localparam int CL = 0;

   function automatic logic code_valid(input logic [2:0] code);
      return (code != CODE_NONE) && (code != CODE_ALL);
   endfunction

   function automatic logic [5:0] high_bit(input phase_t ph);
      logic [5:0] m;
      case (ph)
         PH_A:    m = 6'b000001 << AH;
         PH_B:    m = 6'b000001 << BH;
         default: m = 6'b000001 << CH;
      endcase
      return m;
   endfunction

   function automatic logic [5:0] low_bit(input phase_t ph);
      logic [5:0] m;
      case (ph)
         PH_A:    m = 6'b000001 << AL;
         PH_B:    m = 6'b000001 << BL;
         default: m = 6'b000001 << CL;
      endcase
      return m;
   endfunction

   // Six-step table: forward rows as listed, reverse swaps high and low roles.
   function automatic logic [5:0] gate_map(input logic [2:0] code, input logic dir,
                                           input logic hi_on);
      phase_t     hi;
      phase_t     lo;
      phase_t     tmp;
      logic       known;
      logic [5:0] g;
      hi    = PH_A;
      lo    = PH_B;
      known = 1'b1;
      g     = '0;
      case (code)
         CODE_101: begin hi = PH_A; lo = PH_B; end
         CODE_100: begin hi = PH_A; lo = PH_C; end
         CODE_110: begin hi = PH_B; lo = PH_C; end
         CODE_010: begin hi = PH_B; lo = PH_A; end
         CODE_011: begin hi = PH_C; lo = PH_A; end
         CODE_001: begin hi = PH_C; lo = PH_B; end
         default:  known = 1'b0;
      endcase
      if (!dir) begin
         tmp = hi;
         hi  = lo;
         lo  = tmp;
      end
      if (known) begin
         g = (hi_on ? high_bit(hi) : 6'b000000) | low_bit(lo);
      end
      return g;
   endfunction

endpackage

// File: rtl/bldc_commutator_if.sv
// Input/output bundle of the commutator: PWM/Hall/control in, gate drive out.
// Combinational wiring only.
// No flow control; every signal is level-sampled each clock.
interface bldc_commutator_if;
   logic       EN;
   logic       DIR;
   logic [2:0] HALL;
   logic       PWM;
   logic       FULL;
   logic [5:0] GATE;
   logic [2:0] SECTOR;
   logic       FAULT;

   modport master (output EN, DIR, HALL, PWM, FULL, input GATE, SECTOR, FAULT);
   modport slave  (input EN, DIR, HALL, PWM, FULL, output GATE, SECTOR, FAULT);
endinterface

// File: rtl/bldc_commutator_hall_filter.sv
// Hall conditioning: 2-flop synchronizer then HALL_FILT-sample run-length debounce.
// A raw change reaches code 2 + HALL_FILT cycles later.
// No backpressure; code_seen marks that a code has been accepted since reset.
module hall_filter
   import bldc_pkg::*;
#(
   parameter int HALL_FILT = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] hall_raw,
   output logic [2:0] code,
   output logic       code_seen
);

   logic [2:0] sync1;
   logic [2:0] sync2;
   logic [1:0] sync_vld;
   logic [2:0] cand;
   logic [7:0] run_cnt;
   logic [7:0] run_nxt;

   // Length of the current run of identical synchronized samples, saturating.
   always_comb begin
      run_nxt = 8'd1;
      if (sync2 == cand) begin
         run_nxt = (run_cnt == 8'hFF) ? run_cnt : run_cnt + 8'd1;
      end
   end

   // Synchronizer shift, run tracking and acceptance of a stable code.
   // sync_vld keeps reset-cleared flops from counting as real samples.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1     <= CODE_NONE;
         sync2     <= CODE_NONE;
         sync_vld  <= 2'b00;
         cand      <= CODE_NONE;
         run_cnt   <= 8'd0;
         code      <= CODE_NONE;
         code_seen <= 1'b0;
      end else begin
         sync1    <= hall_raw;
         sync2    <= sync1;
         sync_vld <= {sync_vld[0], 1'b1};
         if (sync_vld[1]) begin
            cand    <= sync2;
            run_cnt <= run_nxt;
            if (run_nxt >= 8'(HALL_FILT)) begin
               code      <= sync2;
               code_seen <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/bldc_commutator.sv
// Six-step BLDC commutator: Hall-driven sector selection, dead-time, fault shutdown.
// GATE is registered one cycle after PWM/FULL; Hall changes act 2+HALL_FILT+1 cycles later.
// No backpressure. Optional stall timeout is compiled in with BLDC_STALL_DET_EN.
module bldc_commutator
   import bldc_pkg::*;
#(
   parameter int HALL_FILT = 4,
   parameter int DEAD      = 16,
   parameter int STALL_W   = 20
) (
   input logic               CLK,
   input logic               RST_N,
   bldc_commutator_if.slave  bus
);

   logic [2:0] code;
   logic       code_seen;
   logic       code_bad;

   state_t     state;
   state_t     state_nxt;
   logic [7:0] dead_cnt;
   logic [7:0] dead_cnt_nxt;
   logic [2:0] dead_code;
   logic [2:0] dead_code_nxt;
   logic [2:0] sector;
   logic [2:0] sector_nxt;
   logic       dir_q;
   logic       dir_nxt;
   logic [5:0] gate;
   logic [5:0] gate_nxt;
   logic       fault;
   logic       fault_nxt;
   logic       stall_hit;

   hall_filter #(
      .HALL_FILT (HALL_FILT)
   ) u_hall_filter (
      .clk       (CLK),
      .rst_n     (RST_N),
      .hall_raw  (bus.HALL),
      .code      (code),
      .code_seen (code_seen)
   );

   // The power-on 000 is not a fault; only a code the filter actually accepted is.
   assign code_bad = code_seen && !code_valid(code);

`ifdef BLDC_STALL_DET_EN
   logic [STALL_W-1:0] stall_cnt;
   logic [STALL_W-1:0] stall_inc;

   assign stall_inc = stall_cnt + {{(STALL_W-1){1'b0}}, 1'b1};
   assign stall_hit = &stall_inc;

   // Cycles spent in the current sector; any sector change leaves DRIVE and clears it.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         stall_cnt <= '0;
      end else if (state == ST_DRIVE && state_nxt == ST_DRIVE) begin
         stall_cnt <= stall_inc;
      end else begin
         stall_cnt <= '0;
      end
   end
`else
   assign stall_hit = 1'b0;
`endif

   // Next state and next registered outputs; priority EN=0 > bad code > change > stall.
   always_comb begin
      state_nxt     = state;
      dead_cnt_nxt  = dead_cnt;
      dead_code_nxt = dead_code;
      sector_nxt    = sector;
      dir_nxt       = dir_q;
      case (state)
         ST_IDLE: begin
            if (bus.EN) begin
               if (code_bad) begin
                  state_nxt = ST_FAULT;
               end else if (code_valid(code)) begin
                  state_nxt     = ST_DEAD;
                  dead_cnt_nxt  = 8'd0;
                  dead_code_nxt = code;
               end
            end
         end
         ST_DEAD: begin
            if (!bus.EN) begin
               state_nxt = ST_IDLE;
            end else if (code_bad) begin
               state_nxt = ST_FAULT;
            end else if (code != dead_code) begin
               // A new sector arrived mid dead-time: restart the full off window.
               dead_cnt_nxt  = 8'd0;
               dead_code_nxt = code;
            end else if (dead_cnt == 8'(DEAD - 1)) begin
               state_nxt  = ST_DRIVE;
               sector_nxt = dead_code;
               dir_nxt    = bus.DIR;
            end else begin
               dead_cnt_nxt = dead_cnt + 8'd1;
            end
         end
         ST_DRIVE: begin
            if (!bus.EN) begin
               state_nxt = ST_IDLE;
            end else if (code_bad) begin
               state_nxt = ST_FAULT;
            end else if (code != sector || bus.DIR != dir_q) begin
               state_nxt     = ST_DEAD;
               dead_cnt_nxt  = 8'd0;
               dead_code_nxt = code;
            end else if (stall_hit) begin
               state_nxt = ST_FAULT;
            end
         end
         default: begin
            if (!bus.EN) begin
               state_nxt = ST_IDLE;
            end
         end
      endcase

      if (state_nxt == ST_IDLE || state_nxt == ST_FAULT) begin
         sector_nxt = CODE_NONE;
      end
      // Gates follow the next state so leaving DRIVE turns them off on that same edge.
      gate_nxt  = (state_nxt == ST_DRIVE) ? gate_map(sector_nxt, dir_nxt, bus.PWM | bus.FULL)
                                          : 6'b000000;
      fault_nxt = (state_nxt == ST_FAULT);
   end

   // State and output registers.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state     <= ST_IDLE;
         dead_cnt  <= 8'd0;
         dead_code <= CODE_NONE;
         sector    <= CODE_NONE;
         dir_q     <= 1'b0;
         gate      <= 6'b000000;
         fault     <= 1'b0;
      end else begin
         state     <= state_nxt;
         dead_cnt  <= dead_cnt_nxt;
         dead_code <= dead_code_nxt;
         sector    <= sector_nxt;
         dir_q     <= dir_nxt;
         gate      <= gate_nxt;
         fault     <= fault_nxt;
      end
   end

   assign bus.GATE   = gate;
   assign bus.SECTOR = sector;
   assign bus.FAULT  = fault;

endmodule

// File: tb/tb_bldc_commutator.sv
// Directed bench for bldc_commutator with a cycle model checked every clock.
// Inputs change on the falling edge; outputs are compared on the falling edge.
// Optional stall check follows BLDC_STALL_DET_EN.
module tb_bldc_commutator;

   localparam int F  = 4;
   localparam int DT = 16;
`ifdef BLDC_STALL_DET_EN
   localparam int SW = 6;
`else
   localparam int SW = 20;
`endif

   localparam int M_IDLE  = 0;
   localparam int M_DEAD  = 1;
   localparam int M_DRIVE = 2;
   localparam int M_FAULT = 3;

   logic CLK;
   logic RST_N;
   int   total = 0;
   int   bad   = 0;

   bldc_commutator_if bus ();

   bldc_commutator #(
      .HALL_FILT (F),
      .DEAD      (DT),
      .STALL_W   (SW)
   ) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   function automatic logic valid3(input logic [2:0] c);
      return (c != 3'b000) && (c != 3'b111);
   endfunction

   // Phase numbers 0=A,1=B,2=C; high gate of phase p is GATE[5-2p], low is GATE[4-2p].
   function automatic logic [5:0] gate_for(input logic [2:0] c, input logic d, input logic on);
      int hi, lo, t;
      case (c)
         3'b101: begin hi = 0; lo = 1; end
         3'b100: begin hi = 0; lo = 2; end
         3'b110: begin hi = 1; lo = 2; end
         3'b010: begin hi = 1; lo = 0; end
         3'b011: begin hi = 2; lo = 0; end
         3'b001: begin hi = 2; lo = 1; end
         default: return 6'b000000;
      endcase
      if (!d) begin
         t = hi; hi = lo; lo = t;
      end
      return (on ? (6'b100000 >> (2 * hi)) : 6'b000000) | (6'b010000 >> (2 * lo));
   endfunction

   // Behavioural model state.
   logic [2:0] raws[$];
   int         ecnt     = 0;
   logic       model_on = 1'b0;
   logic [2:0] m_acc;
   logic       m_seen;
   int         m_mode;
   int         m_left;
   int         m_age;
   logic [2:0] m_tgt;
   logic [2:0] m_sector;
   logic       m_dir;
   logic [5:0] m_gate;
   logic       m_fault;

   always @(posedge CLK) begin
      if (!RST_N) begin
         raws.delete();
         ecnt     = 0;
         m_acc    = 3'b000;
         m_seen   = 1'b0;
         m_mode   = M_IDLE;
         m_left   = 0;
         m_age    = 0;
         m_tgt    = 3'b000;
         m_sector = 3'b000;
         m_dir    = 1'b0;
         m_gate   = 6'b000000;
         m_fault  = 1'b0;
         model_on = 1'b1;
      end else begin
         logic isbad;
         logic ok;
         ecnt++;
         isbad = m_seen && !valid3(m_acc);
         case (m_mode)
            M_IDLE: begin
               if (bus.EN) begin
                  if (isbad) m_mode = M_FAULT;
                  else if (valid3(m_acc)) begin
                     m_mode = M_DEAD; m_left = DT; m_tgt = m_acc;
                  end
               end
            end
            M_DEAD: begin
               if (!bus.EN) m_mode = M_IDLE;
               else if (isbad) m_mode = M_FAULT;
               else if (m_acc != m_tgt) begin
                  m_left = DT; m_tgt = m_acc;
               end else begin
                  m_left--;
                  if (m_left == 0) begin
                     m_mode = M_DRIVE; m_sector = m_tgt; m_dir = bus.DIR; m_age = 0;
                  end
               end
            end
            M_DRIVE: begin
               if (!bus.EN) m_mode = M_IDLE;
               else if (isbad) m_mode = M_FAULT;
               else if (m_acc != m_sector || bus.DIR != m_dir) begin
                  m_mode = M_DEAD; m_left = DT; m_tgt = m_acc;
               end else begin
                  m_age++;
`ifdef BLDC_STALL_DET_EN
                  if (m_age == (1 << SW) - 1) m_mode = M_FAULT;
`endif
               end
            end
            default: begin
               if (!bus.EN) m_mode = M_IDLE;
            end
         endcase
         if (m_mode == M_IDLE || m_mode == M_FAULT) m_sector = 3'b000;
         m_fault = (m_mode == M_FAULT);
         m_gate  = (m_mode == M_DRIVE) ? gate_for(m_sector, m_dir, bus.PWM | bus.FULL)
                                       : 6'b000000;
         // Filter view: raw value seen at edge n reaches the debouncer at edge n+2;
         // a code is accepted once the last F such samples agree.
         if (ecnt >= F + 2) begin
            ok = 1'b1;
            for (int j = ecnt - 2 - F; j <= ecnt - 3; j++) begin
               if (raws[j] != raws[ecnt-3]) ok = 1'b0;
            end
            if (ok) begin
               m_acc  = raws[ecnt-3];
               m_seen = 1'b1;
            end
         end
         raws.push_back(bus.HALL);
      end
   end

   always @(negedge CLK) begin
      if (model_on) begin
         chk("gate", 8'(bus.GATE), 8'(m_gate));
         chk("sector", 8'(bus.SECTOR), 8'(m_sector));
         chk("fault", 8'(bus.FAULT), 8'(m_fault));
         chk("shoot_through", 8'({bus.GATE[5] & bus.GATE[4], bus.GATE[3] & bus.GATE[2],
                                  bus.GATE[1] & bus.GATE[0]}), 8'd0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      RST_N    = 1'b0;
      bus.EN   = 1'b0;
      bus.DIR  = 1'b1;
      bus.HALL = 3'b000;
      bus.PWM  = 1'b0;
      bus.FULL = 1'b0;
      tick(3);
      chk("rst_gate", 8'(bus.GATE), 8'b00000000);
      chk("rst_sector", 8'(bus.SECTOR), 8'd0);
      chk("rst_fault", 8'(bus.FAULT), 8'd0);

      // Start-up in forward sector 101 with PWM high.
      RST_N = 1'b1; bus.EN = 1'b1; bus.HALL = 3'b101; bus.PWM = 1'b1;
      tick(22); chk("start_off", 8'(bus.GATE), 8'b00000000);
      tick(1);  chk("start_gate", 8'(bus.GATE), 8'b00100100);
      chk("start_sector", 8'(bus.SECTOR), 8'b00000101);

      // Sector step 101 -> 100.
      bus.HALL = 3'b100;
      tick(6);  chk("step_hold", 8'(bus.GATE), 8'b00100100);
      tick(1);  chk("step_off", 8'(bus.GATE), 8'b00000000);
      tick(15); chk("step_off_end", 8'(bus.GATE), 8'b00000000);
      tick(1);  chk("step_gate", 8'(bus.GATE), 8'b00100001);
      chk("step_sector", 8'(bus.SECTOR), 8'b00000100);

      // One cycle of PWM latency on the high gate.
      bus.PWM = 1'b0;
      tick(1);  chk("pwm_low", 8'(bus.GATE), 8'b00000001);
      bus.PWM = 1'b1;
      tick(1);  chk("pwm_high", 8'(bus.GATE), 8'b00100001);

      // Back to 101, then a 3-cycle glitch that the filter must reject.
      bus.HALL = 3'b101;
      tick(30); chk("back_gate", 8'(bus.GATE), 8'b00100100);
      bus.HALL = 3'b100;
      tick(3);
      bus.HALL = 3'b101;
      tick(20); chk("glitch_gate", 8'(bus.GATE), 8'b00100100);
      chk("glitch_sector", 8'(bus.SECTOR), 8'b00000101);

      // Invalid code 111 faults and stays until EN drops.
      bus.HALL = 3'b111;
      tick(6);  chk("inv_pre", 8'(bus.FAULT), 8'd0);
      tick(1);  chk("inv_fault", 8'(bus.FAULT), 8'd1);
      chk("inv_gate", 8'(bus.GATE), 8'b00000000);
      chk("inv_sector", 8'(bus.SECTOR), 8'd0);
      tick(10); chk("inv_sticky", 8'(bus.FAULT), 8'd1);
      bus.EN = 1'b0;
      tick(1);  chk("fault_clear", 8'(bus.FAULT), 8'd0);

      // Reverse direction, FULL instead of PWM.
      bus.HALL = 3'b101;
      tick(10);
      bus.DIR = 1'b0; bus.PWM = 1'b0; bus.FULL = 1'b1; bus.EN = 1'b1;
      tick(16); chk("rev_off", 8'(bus.GATE), 8'b00000000);
      tick(1);  chk("rev_gate", 8'(bus.GATE), 8'b00011000);

      // DIR toggle forces a full dead window.
      bus.DIR = 1'b1;
      tick(1);  chk("dir_off", 8'(bus.GATE), 8'b00000000);
      tick(15); chk("dir_off_end", 8'(bus.GATE), 8'b00000000);
      tick(1);  chk("dir_gate", 8'(bus.GATE), 8'b00100100);

      // A second change during dead time restarts the window with the new code.
      bus.HALL = 3'b100;
      tick(7);
      bus.HALL = 3'b110;
      tick(22); chk("restart_off", 8'(bus.GATE), 8'b00000000);
      tick(1);  chk("restart_gate", 8'(bus.GATE), 8'b00001001);

      // Frozen Hall in DRIVE.
      tick(100);
`ifdef BLDC_STALL_DET_EN
      chk("stall_fault", 8'(bus.FAULT), 8'd1);
`else
      chk("no_stall_fault", 8'(bus.FAULT), 8'd0);
`endif

      // Re-enter DRIVE, then reset mid-DRIVE drops gates on that edge.
      bus.EN = 1'b0;
      tick(2);  chk("idle_sector", 8'(bus.SECTOR), 8'd0);
      bus.EN = 1'b1;
      tick(17); chk("redrive_gate", 8'(bus.GATE), 8'b00001001);
      RST_N = 1'b0;
      tick(1);  chk("rst_mid_gate", 8'(bus.GATE), 8'b00000000);
      chk("rst_mid_sector", 8'(bus.SECTOR), 8'd0);
      tick(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bldc_commutator.md
Name: bldc_commutator

Overview:
- Six-step commutation stage that sits directly downstream of the 8-bit PWM generator in the BLDC controller.
- Consumes the PWM chop output and the 100%-duty flag, plus the three Hall sensor lines.
- Produces six registered gate drives (A/B/C high and low), with dead-time insertion on every sector change and fault shutdown on invalid Hall codes.

Parameters:
- HALL_FILT, 4: consecutive identical synchronized Hall samples required before a code is accepted (1..255).
- DEAD, 16: all-gates-off cycles inserted on every sector change (1..255).
- STALL_W, 20: width of the stall timeout counter; used only with the optional feature.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST_N  in  1  synchronous reset, active-low.
- EN  in  1  drive enable; same enable that gates the PWM generator.
- DIR  in  1  1 = forward table, 0 = reverse (high/low phase roles swapped).
- HALL  in  3  raw asynchronous Hall sensors {Ha,Hb,Hc}.
- PWM  in  1  chop signal from the PWM generator.
- FULL  in  1  100%-duty flag from the PWM generator.
- GATE  out  6  {AH,AL,BH,BL,CH,CL}, registered.
- SECTOR  out  3  current accepted Hall code; 0 when none is accepted.
- FAULT  out  1  sticky fault flag, registered.

Behaviour:
- Reset (RST_N=0 at a CLK edge):
  - GATE=0, SECTOR=0, FAULT=0, state=IDLE.
  - Synchronizer and filter cleared; filtered code = 000.
- Hall path:
  - 2-flop synchronizer, then filter.
  - Filter accepts a new code after HALL_FILT consecutive equal samples.
  - Latency from a raw HALL change to the accepted code = 2 + HALL_FILT cycles.
- Forward table (DIR=1), code -> high phase / low phase:
  - 101 -> A / B
  - 100 -> A / C
  - 110 -> B / C
  - 010 -> B / A
  - 011 -> C / A
  - 001 -> C / B
- Reverse table (DIR=0): same rows with the high and low phases swapped.
- Gate drive in DRIVE:
  - Selected high gate = PWM | FULL, registered, so 1 cycle of latency from PWM.
  - Selected low gate = 1.
  - The other four gates = 0.
- State machine (IDLE, DEAD, DRIVE, FAULT):
  - IDLE: GATE=0. Moves to DEAD when EN=1 and the accepted code is valid (not 000 or 111). Moves to FAULT when EN=1 and the code is invalid after filtering.
  - DEAD: GATE=0, counter runs DEAD cycles, then DRIVE with SECTOR = accepted code.
  - DRIVE:
    - Accepted code changes to a valid code, or DIR toggles: go to DEAD.
    - Code becomes invalid: go to FAULT.
    - EN=0: go to IDLE.
  - FAULT: GATE=0, FAULT=1. Leaves only on EN=0, going to IDLE with FAULT cleared on that edge.
- SECTOR updates on the DEAD->DRIVE transition and clears to 0 on entry to IDLE or FAULT.
- Invariants:
  - xH and xL are never 1 together.
  - Any high/low transfer between phases passes through ≥DEAD all-off cycles.
- Simultaneous events, priority: RST_N > EN=0 > invalid code > code change.
- A code change during DEAD restarts the DEAD count with the new code.
- Reset mid-DRIVE: gates drop to 0 on that same edge.

Optional Feature:
- Macro: BLDC_STALL_DET_EN.
- Defined:
  - Counter of STALL_W bits increments each DRIVE cycle and clears on every accepted code change.
  - At all-ones: go to FAULT, FAULT=1.
- Undefined: no counter and no stall fault; STALL_W is ignored.

Decomposition:
- Package bldc_pkg holds:
  - state enum (IDLE, DEAD, DRIVE, FAULT)
  - Hall code constants
  - GATE bit index constants (AH=5 .. CL=0)
- One sub-module, hall_filter (synchronizer plus HALL_FILT debounce). Commutation table and FSM stay in the top module.

Test Plan:
- Reset then EN=1, HALL=101, DIR=1, PWM=1: GATE=000000 for 2+4+16 cycles, then GATE=100100, SECTOR=101.
- In DRIVE with code 101, HALL steps to 100: after 6 cycles GATE=000000 for 16 cycles, then 100001. No cycle ever has AH&AL, BH&BL or CH&CL set.
- HALL glitch 101->100->101 lasting 3 cycles (below HALL_FILT=4): GATE unchanged at 100100, no DEAD entry.
- HALL=111 in DRIVE: after 6 cycles GATE=0 and FAULT=1. Holding EN=1 keeps FAULT=1. EN=0 gives IDLE and FAULT=0 on the next edge.
- DIR=0 with HALL=101, PWM=0, FULL=1: GATE=011000 (BH=1, AL=1). Toggling DIR in DRIVE forces 16 all-off cycles.
- With BLDC_STALL_DET_EN and STALL_W=4: HALL frozen in DRIVE makes FAULT=1 after 15 DRIVE cycles. Without the macro, FAULT stays 0.
